// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared constants for the square-wave test source.
// Holds the sel encoding, the FSM state type, the preset half-period
// helpers (derived from the system clock rate) and the fast-output
// threshold used by hf_led.
package freq_gen_pkg;

  // Source select encoding
  localparam logic [1:0] SEL_CUSTOM = 2'b00;
  localparam logic [1:0] SEL_4HZ    = 2'b01;
  localparam logic [1:0] SEL_1KHZ   = 2'b10;
  localparam logic [1:0] SEL_5MHZ   = 2'b11;

  // Preset output frequencies in Hz
  localparam longint unsigned F_4HZ  = 64'd4;
  localparam longint unsigned F_1KHZ = 64'd1_000;
  localparam longint unsigned F_5MHZ = 64'd5_000_000;

  // Half-period at or below this many clk cycles means output >= 1 MHz
  localparam int unsigned HF_THRESH = 25;

  // Power-on custom half-period (1 kHz at 50 MHz)
  localparam int unsigned CUSTOM_RST = 25_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Half-period in clk cycles for a given output frequency
  function automatic longint unsigned half_for(longint unsigned clk_hz,
                                               longint unsigned out_hz);
    return clk_hz / (64'd2 * out_hz);
  endfunction

  // True when a half-period is representable in a w-bit counter and non-zero
  function automatic bit fits(longint unsigned v, int unsigned w);
    return (v >= 64'd1) && (v <= ((64'd1 << w) - 64'd1));
  endfunction

endpackage

// File: rtl/freq_gen_div.sv
// freq_gen_div: phase counter for freq_gen.
// Latches the half-period of the phase being started and counts clk
// cycles within the phase; bnd flags the last cycle of the phase.
module freq_gen_div
  import freq_gen_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] nxt_half,
  output logic [DIV_W-1:0] act_half,
  output logic             bnd
);

  logic [DIV_W-1:0] cnt;

  // Start a phase (load), park the counter (clr) or advance within a phase
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt      <= '0;
      act_half <= '0;
    end else if (load) begin
      cnt      <= '0;
      act_half <= nxt_half;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Full-width compare against the latched half-period
  assign bnd = (cnt == (act_half - 1'b1));

endmodule

// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave test source for the frequency meter.
// Three fixed presets (4 Hz, 1 kHz, 5 MHz) plus a custom half-period loaded
// over a req/ack handshake. A new half-period is only picked up at a phase
// boundary, so the output never produces runt pulses.
// Optional feature macro: FREQ_GEN_DUTY_EN adds div_lo_in / custom_lo so the
// custom LOW phase can differ from the HIGH phase.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int              DIV_W  = 24,
  parameter longint unsigned CLK_HZ = 64'd50_000_000
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic [DIV_W-1:0] div_in,
`ifdef FREQ_GEN_DUTY_EN
  input  logic [DIV_W-1:0] div_lo_in,
`endif
  input  logic             load_req,
  output logic             load_ack,
  output logic             clk_out,
  output logic             period_tick,
  output logic             hf_led
);

  localparam longint unsigned P_4HZ  = half_for(CLK_HZ, F_4HZ);
  localparam longint unsigned P_1KHZ = half_for(CLK_HZ, F_1KHZ);
  localparam longint unsigned P_5MHZ = half_for(CLK_HZ, F_5MHZ);

  localparam logic [DIV_W-1:0] H_4HZ    = DIV_W'(P_4HZ);
  localparam logic [DIV_W-1:0] H_1KHZ   = DIV_W'(P_1KHZ);
  localparam logic [DIV_W-1:0] H_5MHZ   = DIV_W'(P_5MHZ);
  localparam logic [DIV_W-1:0] H_RST    = DIV_W'(CUSTOM_RST);
  localparam logic [DIV_W-1:0] H_HF     = DIV_W'(HF_THRESH);
  localparam logic [DIV_W-1:0] H_ONE    = DIV_W'(1);

  // Presets must fit the counter; a bad DIV_W/CLK_HZ pair stops elaboration
  if (!fits(P_4HZ, DIV_W) || !fits(P_1KHZ, DIV_W) || !fits(P_5MHZ, DIV_W))
  begin : g_bad_preset
    $error("freq_gen: preset half-period does not fit in DIV_W bits");
  end

  state_t           state, state_nxt;
  logic [DIV_W-1:0] custom_half;
  logic [DIV_W-1:0] eff_hi, eff_lo;
  logic [DIV_W-1:0] nxt_half;
  logic [DIV_W-1:0] act_half;
  logic             dv_load, dv_clr, dv_run, bnd;

  // Custom half-period capture; a zero request is clamped to 1 cycle
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      custom_half <= H_RST;
      load_ack    <= 1'b0;
    end else begin
      load_ack <= load_req;
      if (load_req) custom_half <= (div_in == '0) ? H_ONE : div_in;
    end
  end

`ifdef FREQ_GEN_DUTY_EN
  logic [DIV_W-1:0] custom_lo;

  // Custom LOW length, captured on the same handshake as custom_half
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      custom_lo <= H_RST;
    end else if (load_req) begin
      custom_lo <= (div_lo_in == '0) ? H_ONE : div_lo_in;
    end
  end
`endif

  // Half-period selected by sel for HIGH phases
  always_comb begin
    eff_hi = custom_half;
    case (sel)
      SEL_CUSTOM: eff_hi = custom_half;
      SEL_4HZ:    eff_hi = H_4HZ;
      SEL_1KHZ:   eff_hi = H_1KHZ;
      SEL_5MHZ:   eff_hi = H_5MHZ;
      default:    eff_hi = custom_half;
    endcase
  end

  // LOW phase length: own register in custom duty mode, else same as HIGH
  always_comb begin
`ifdef FREQ_GEN_DUTY_EN
    eff_lo = (sel == SEL_CUSTOM) ? custom_lo : eff_hi;
`else
    eff_lo = eff_hi;
`endif
  end

  freq_gen_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .Rst_n   (Rst_n),
    .load    (dv_load),
    .clr     (dv_clr),
    .run     (dv_run),
    .nxt_half(nxt_half),
    .act_half(act_half),
    .bnd     (bnd)
  );

  // State register
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and phase-counter control
  always_comb begin
    state_nxt = state;
    dv_load   = 1'b0;
    dv_clr    = 1'b0;
    dv_run    = 1'b0;
    nxt_half  = eff_hi;
    case (state)
      ST_IDLE: begin
        dv_clr = 1'b1;
        if (enable) begin
          state_nxt = ST_HIGH;
          dv_load   = 1'b1;
        end
      end
      ST_HIGH: begin
        // A HIGH phase always runs to completion, even if enable drops
        if (bnd) begin
          dv_load   = 1'b1;
          nxt_half  = eff_lo;
          state_nxt = enable ? ST_LOW : ST_IDLE;
        end else begin
          dv_run = 1'b1;
        end
      end
      ST_LOW: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          dv_clr    = 1'b1;
        end else if (bnd) begin
          state_nxt = ST_HIGH;
          dv_load   = 1'b1;
        end else begin
          dv_run = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dv_clr    = 1'b1;
      end
    endcase
  end

  // Registered outputs; tick marks the cycle where clk_out goes 0 -> 1
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
      hf_led      <= 1'b0;
    end else begin
      clk_out     <= (state == ST_HIGH);
      period_tick <= (state == ST_HIGH) && !clk_out;
      hf_led      <= (state != ST_IDLE) && (act_half <= H_HF);
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed bench for freq_gen with a period scoreboard.
// Stimulus pushes expected {period, high time} records; a monitor measures
// each interval between period_tick pulses and pops/compares.
module tb_freq_gen;
  import freq_gen_pkg::*;

  localparam int DIV_W = 24;

  logic             clk;
  logic             Rst_n;
  logic             enable;
  logic [1:0]       sel;
  logic [DIV_W-1:0] div_in;
  logic             load_req;
  logic             load_ack;
  logic             clk_out;
  logic             period_tick;
  logic             hf_led;

  freq_gen #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .enable     (enable),
    .sel        (sel),
    .div_in     (div_in),
`ifdef FREQ_GEN_DUTY_EN
    .div_lo_in  (div_in),
`endif
    .load_req   (load_req),
    .load_ack   (load_ack),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .hf_led     (hf_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass, n_tot;
  int   cyc, last, hcnt;
  bit   last_ok;
  exp_t e;

  task automatic check(string nm, longint act, longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_per(int per, int hi, int n);
    exp_t x;
    x.per = per;
    x.hi  = hi;
    repeat (n) exp_q.push_back(x);
  endtask

  // Wait (bounded) for the scoreboard to empty, then insist it did
  task automatic wait_drain(string nm, int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Wait (bounded) for the next period_tick, sampled on a falling edge
  task automatic wait_tick(string nm, int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < lim);
    check(nm, period_tick, 1);
  endtask

  // One-cycle custom load handshake
  task automatic do_load(logic [DIV_W-1:0] v);
    div_in   = v;
    load_req = 1'b1;
    @(negedge clk);
    check("load_ack_hi", load_ack, 1);
    load_req = 1'b0;
    @(negedge clk);
    check("load_ack_lo", load_ack, 0);
  endtask

  initial begin
    n_pass   = 0;
    n_tot    = 0;
    cyc      = 0;
    last     = 0;
    hcnt     = 0;
    last_ok  = 1'b0;
    Rst_n    = 1'b0;
    enable   = 1'b0;
    sel      = SEL_CUSTOM;
    div_in   = '0;
    load_req = 1'b0;

    fork
      begin : mon
        forever begin
          @(posedge clk);
          #2;
          cyc++;
          if (!enable || !Rst_n) begin
            last_ok = 1'b0;
          end else if (period_tick) begin
            if (last_ok && exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("period", cyc - last, e.per);
              check("high_time", hcnt, e.hi);
            end
            last    = cyc;
            last_ok = 1'b1;
            hcnt    = 1;
          end else if (clk_out) begin
            hcnt++;
          end
        end
      end
      begin : stim
        // Reset and idle: everything low, no acks
        cycles(3);
        check("rst_outs", {clk_out, period_tick, hf_led, load_ack}, 0);
        Rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check("idle_outs", {clk_out, period_tick, hf_led, load_ack}, 0);
        end

        // 5 MHz preset: 5 high / 5 low, first rise two edges after enable
        sel = SEL_5MHZ;
        push_per(10, 5, 4);
        enable = 1'b1;
        @(negedge clk);
        check("start_lat_0", clk_out, 0);
        @(negedge clk);
        check("start_lat_1", {clk_out, period_tick}, 2'b11);
        wait_drain("drain_5mhz", 100);
        check("hf_5mhz", hf_led, 1);
        enable = 1'b0;
        cycles(12);

        // Custom load of 0 clamps to 1: period 2
        sel = SEL_CUSTOM;
        do_load('0);
        check("custom_clamp", dut.custom_half, 1);
        push_per(2, 1, 4);
        enable = 1'b1;
        wait_drain("drain_n1", 50);
        check("hf_n1", hf_led, 1);
        enable = 1'b0;
        cycles(6);

        // N=7, then drop enable on HIGH cycle 4: HIGH still lasts 7
        do_load(7);
        push_per(14, 7, 2);
        enable = 1'b1;
        wait_drain("drain_n7", 100);
        wait_tick("tick_n7", 40);
        cycles(3);
        enable = 1'b0;
        hcnt = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!clk_out) break;
          hcnt++;
        end
        check("high_after_drop", hcnt, 3);
        check("idle_after_high", int'(dut.state), int'(ST_IDLE));
        hcnt = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (clk_out || period_tick) hcnt++;
        end
        check("quiet_after_high", hcnt, 0);

        // Drop enable during LOW: IDLE on the next edge
        enable = 1'b1;
        wait_tick("tick_low", 40);
        for (int i = 0; i < 20 && clk_out; i++) @(negedge clk);
        check("in_low", {clk_out, int'(dut.state)}, {1'b0, 2'(ST_LOW)});
        enable = 1'b0;
        @(negedge clk);
        check("idle_after_low", int'(dut.state), int'(ST_IDLE));
        cycles(6);

        // 1 kHz running, switch to 5 MHz mid-HIGH: current phase unchanged
        sel = SEL_1KHZ;
        push_per(25_005, 25_000, 1);
        push_per(10, 5, 3);
        enable = 1'b1;
        wait_tick("tick_1khz", 100);
        cycles(2);
        sel = SEL_5MHZ;
        check("hf_1khz", hf_led, 0);
        wait_drain("drain_switch", 26_000);
        check("hf_after_switch", hf_led, 1);
        enable = 1'b0;
        cycles(12);

        // Async reset mid-HIGH: output drops without a clock edge
        sel = SEL_CUSTOM;
        do_load(40);
        enable = 1'b1;
        wait_tick("tick_n40", 40);
        cycles(2);
        check("pre_rst_high", {clk_out, dut.custom_half}, {1'b1, 24'd40});
        Rst_n = 1'b0;
        #1;
        check("async_rst_outs", {clk_out, period_tick, hf_led, load_ack}, 0);
        check("rst_custom", dut.custom_half, 25_000);
        enable = 1'b0;
        @(negedge clk);
        Rst_n = 1'b1;
        cycles(3);
        check("post_rst_idle", {clk_out, int'(dut.state)}, {1'b0, 2'(ST_IDLE)});
        enable = 1'b1;
        cycles(2);
        check("restart_rise", clk_out, 1);
        enable = 1'b0;
        cycles(4);
      end
    join_any
    disable fork;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
